sweep_ctl: RTL and testbench

SWEEP_CTL -- requirements
Module: sweep_ctl

---
 rtl/sweep_ctl.sv | 143 ++++++++++++++
 tb/tb_sweep_ctl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctl.sv
// Cache sweep sequencer: walks line/way addresses for whole-cache or single-page
// sweeps, handshakes each step with the MBOX, then drains writebacks and reports done.
module sweep_ctl (
    input  logic       clk,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] FUNC,
    input  logic       ONE_PAGE,
    input  logic [8:0] PAGE,
    input  logic       SWP_ACK,
    input  logic       SWP_ERR,
    input  logic       MBOX_IDLE,
    output logic       SWP_REQ,
    output logic [6:0] SWP_LINE,
    output logic [1:0] SWP_WAY,
    output logic [1:0] SWP_FUNC,
    output logic       SWP_PAGE_EN,
    output logic [8:0] SWP_PAGE,
    output logic       SWEEP_BUSY_EN,
    output logic       SWEEP_BUSY,
    output logic       SWEEP_ERR
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state_q,   state_d;
    logic [8:0] cnt_q,     cnt_d;
    logic [1:0] func_q,    func_d;
    logic       page_en_q, page_en_d;
    logic [8:0] page_q,    page_d;
    logic       err_q,     err_d;
    logic       req_q;
    logic       busy_q;

    logic [8:0] step_s;
    logic       last_step_s;
    logic       busy_en_s;

    // Page sweeps visit way 0 of every line only, so they stride by a whole line.
    always_comb begin
        if (page_en_q) begin
            step_s      = 9'd4;
            last_step_s = (cnt_q == 9'd508);
        end else begin
            step_s      = 9'd1;
            last_step_s = (cnt_q == 9'd511);
        end
    end

    // Busy covers the stepping and writeback-drain phases only.
    always_comb begin
        busy_en_s = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    end

    // Next-state and operand-latch logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        func_d    = func_q;
        page_en_d = page_en_q;
        page_d    = page_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    func_d    = FUNC;
                    page_en_d = ONE_PAGE;
                    page_d    = PAGE;
                    cnt_d     = 9'd0;
                    err_d     = 1'b0;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (SWP_ACK) begin
                    if (SWP_ERR) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else if (last_step_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d   = cnt_q + step_s;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (MBOX_IDLE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 9'd0;
            func_q    <= 2'b00;
            page_en_q <= 1'b0;
            page_q    <= 9'd0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func_q    <= func_d;
            page_en_q <= page_en_d;
            page_q    <= page_d;
            err_q     <= err_d;
            req_q     <= (state_d == ST_ISSUE);
            busy_q    <= busy_en_s;
        end
    end

    assign SWP_REQ       = req_q;
    assign SWP_LINE      = cnt_q[8:2];
    assign SWP_WAY       = cnt_q[1:0];
    assign SWP_FUNC      = func_q;
    assign SWP_PAGE_EN   = page_en_q;
    assign SWP_PAGE      = page_q;
    assign SWEEP_BUSY_EN = busy_en_s;
    assign SWEEP_BUSY    = busy_q;
    assign SWEEP_ERR     = err_q;

endmodule

// File: tb/tb_sweep_ctl.sv
// Scoreboard bench for sweep_ctl: stimulus queues expected sweep steps, a negedge
// monitor pops and compares them on every accepted request.
module tb_sweep_ctl;

    logic       clk = 1'b0;
    logic       RESET, START, ONE_PAGE, SWP_ACK, SWP_ERR, MBOX_IDLE;
    logic [1:0] FUNC;
    logic [8:0] PAGE;
    logic       SWP_REQ, SWP_PAGE_EN, SWEEP_BUSY_EN, SWEEP_BUSY, SWEEP_ERR;
    logic [6:0] SWP_LINE;
    logic [1:0] SWP_WAY, SWP_FUNC;
    logic [8:0] SWP_PAGE;

    always #5 clk = ~clk;

    sweep_ctl dut (
        .clk(clk), .RESET(RESET), .START(START), .FUNC(FUNC), .ONE_PAGE(ONE_PAGE),
        .PAGE(PAGE), .SWP_ACK(SWP_ACK), .SWP_ERR(SWP_ERR), .MBOX_IDLE(MBOX_IDLE),
        .SWP_REQ(SWP_REQ), .SWP_LINE(SWP_LINE), .SWP_WAY(SWP_WAY), .SWP_FUNC(SWP_FUNC),
        .SWP_PAGE_EN(SWP_PAGE_EN), .SWP_PAGE(SWP_PAGE), .SWEEP_BUSY_EN(SWEEP_BUSY_EN),
        .SWEEP_BUSY(SWEEP_BUSY), .SWEEP_ERR(SWEEP_ERR)
    );

    typedef struct {
        logic [6:0] line;
        logic [1:0] way;
        logic [1:0] func;
        logic       pen;
        logic [8:0] page;
    } step_t;

    step_t sb[$];
    int tests = 0, fails = 0;
    int hold = 0, run = 0, last_run = 0, drain_len = 0, last_drain = 0, done_cnt = 0;
    int exp_hold = 1;
    int ack_delay = 0, err_step = -1, rst_step = -1, busy_step = -1, idle_hold = 0;
    bit err_noack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted step and tracks run/drain/done timing.
    always @(negedge clk) begin
        if (SWP_REQ === 1'b1) begin
            hold++;
            run++;
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (SWP_REQ === 1'b1 && SWP_ACK === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_step: got line %0d way %0d expected none", SWP_LINE, SWP_WAY);
            end else begin
                step_t e;
                e = sb.pop_front();
                chk("step_line", 32'(SWP_LINE), 32'(e.line));
                chk("step_way", 32'(SWP_WAY), 32'(e.way));
                chk("step_func", 32'(SWP_FUNC), 32'(e.func));
                chk("step_page_en", 32'(SWP_PAGE_EN), 32'(e.pen));
                chk("step_page", 32'(SWP_PAGE), 32'(e.page));
                chk("step_hold", 32'(hold), 32'(exp_hold));
            end
            hold = 0;
        end
        if (SWEEP_BUSY_EN === 1'b1 && SWP_REQ === 1'b0) drain_len++;
        if (SWEEP_BUSY === 1'b1 && SWEEP_BUSY_EN === 1'b0) begin
            done_cnt++;
            last_drain = drain_len;
            drain_len = 0;
        end
    end

    task automatic push_steps(input int n, input bit pen, input logic [1:0] f, input logic [8:0] pg);
        for (int i = 0; i < n; i++) begin
            step_t e;
            logic [8:0] c;
            c = pen ? 9'(i * 4) : 9'(i);
            e.line = c[8:2];
            e.way  = c[1:0];
            e.func = f;
            e.pen  = pen;
            e.page = pg;
            sb.push_back(e);
        end
    endtask

    task automatic start_sweep(input logic [1:0] f, input bit pen, input logic [8:0] pg);
        START = 1'b1; FUNC = f; ONE_PAGE = pen; PAGE = pg;
        @(posedge clk); #1;
        START = 1'b0; FUNC = ~f; ONE_PAGE = ~pen; PAGE = ~pg;
        chk("start_latency", 32'(SWP_REQ), 32'd1);
        chk("first_addr", 32'({SWP_LINE, SWP_WAY}), 32'd0);
        chk("err_cleared", 32'(SWEEP_ERR), 32'd0);
    endtask

    // MBOX model: acks after ack_delay wait cycles, injects err/start/reset at chosen steps.
    task automatic run_sweep(input int budget, output bit aborted);
        int cyc = 0, w = 0, d = 0;
        bit fin = 1'b0, fired = 1'b0;
        logic [8:0] a;
        aborted = 1'b0;
        while (!fin) begin
            if (SWEEP_BUSY && !SWEEP_BUSY_EN) begin
                fin = 1'b1;
            end else if (cyc >= budget) begin
                tests++;
                fails++;
                $display("FAIL sweep_timeout: got %0d cycles required done within %0d", cyc, budget);
                fin = 1'b1;
            end else begin
                START = 1'b0;
                if (SWP_REQ) begin
                    a = {SWP_LINE, SWP_WAY};
                    if (w == ack_delay) begin SWP_ACK = 1'b1; w = 0; end
                    else begin SWP_ACK = 1'b0; w++; end
                    SWP_ERR = (SWP_ACK && int'(a) == err_step) || (err_noack && !SWP_ACK);
                    if (!fired && int'(a) == busy_step) begin
                        START = 1'b1; FUNC = 2'b01; ONE_PAGE = 1'b1; PAGE = 9'h0FF; fired = 1'b1;
                    end
                    if (int'(a) == rst_step) begin RESET = 1'b1; aborted = 1'b1; fin = 1'b1; end
                end else begin
                    SWP_ACK = 1'b0; SWP_ERR = 1'b0;
                end
                if (SWEEP_BUSY_EN && !SWP_REQ) begin
                    d++;
                    MBOX_IDLE = (d > idle_hold);
                end
                cyc++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", 32'(SWP_REQ), 32'd0);
        chk("rst_line", 32'(SWP_LINE), 32'd0);
        chk("rst_way", 32'(SWP_WAY), 32'd0);
        chk("rst_func", 32'(SWP_FUNC), 32'd0);
        chk("rst_page_en", 32'(SWP_PAGE_EN), 32'd0);
        chk("rst_page", 32'(SWP_PAGE), 32'd0);
        chk("rst_busy_en", 32'(SWEEP_BUSY_EN), 32'd0);
        chk("rst_busy", 32'(SWEEP_BUSY), 32'd0);
        chk("rst_err", 32'(SWEEP_ERR), 32'd0);
    endtask

    task automatic end_checks(input int prev_done, input int exp_drain, input int exp_run, input bit exp_err);
        @(posedge clk); #1;
        SWP_ACK = 1'b0; SWP_ERR = 1'b0; MBOX_IDLE = 1'b1;
        chk("done_pulses", 32'(done_cnt), 32'(prev_done + 1));
        chk("drain_cycles", 32'(last_drain), 32'(exp_drain));
        chk("req_run", 32'(last_run), 32'(exp_run));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("sweep_err", 32'(SWEEP_ERR), 32'(exp_err));
        chk("busy_after_done", 32'(SWEEP_BUSY), 32'd0);
        chk("req_after_done", 32'(SWP_REQ), 32'd0);
    endtask

    initial begin
        int pd;
        bit ab;
        RESET = 1'b1; START = 1'b0; FUNC = 2'b00; ONE_PAGE = 1'b0; PAGE = 9'd0;
        SWP_ACK = 1'b0; SWP_ERR = 1'b0; MBOX_IDLE = 1'b1;
        repeat (2) @(posedge clk);
        #1 START = 1'b1; FUNC = 2'b11; PAGE = 9'h1FF;
        @(posedge clk); #1;
        START = 1'b0;
        chk_reset_vals();
        RESET = 1'b0;

        // Full invalidate, ack every cycle.
        pd = done_cnt; ack_delay = 0; exp_hold = 1;
        push_steps(512, 1'b0, 2'b00, 9'h055);
        start_sweep(2'b00, 1'b0, 9'h055);
        run_sweep(2000, ab);
        end_checks(pd, 1, 512, 1'b0);

        // Page unload, ack after 3 wait cycles, stray SWP_ERR without ACK.
        pd = done_cnt; ack_delay = 3; exp_hold = 4; err_noack = 1'b1;
        push_steps(128, 1'b1, 2'b10, 9'h1A5);
        start_sweep(2'b10, 1'b1, 9'h1A5);
        run_sweep(3000, ab);
        end_checks(pd, 1, 512, 1'b0);
        chk("page_latched", 32'(SWP_PAGE), 32'h1A5);
        chk("page_en_latched", 32'(SWP_PAGE_EN), 32'd1);
        err_noack = 1'b0;

        // Error abort at step 37 with a 5-cycle MBOX writeback stall.
        pd = done_cnt; ack_delay = 0; exp_hold = 1; err_step = 37; idle_hold = 5;
        MBOX_IDLE = 1'b0;
        push_steps(38, 1'b0, 2'b11, 9'h000);
        start_sweep(2'b11, 1'b0, 9'h000);
        run_sweep(2000, ab);
        end_checks(pd, 6, 38, 1'b1);
        err_step = -1; idle_hold = 0;
        SWP_ACK = 1'b1; SWP_ERR = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ack_ignored", 32'(SWP_REQ), 32'd0);
        chk("idle_busy_en", 32'(SWEEP_BUSY_EN), 32'd0);
        chk("err_sticky", 32'(SWEEP_ERR), 32'd1);
        SWP_ACK = 1'b0; SWP_ERR = 1'b0;

        // Second START while busy must be ignored.
        pd = done_cnt; busy_step = 10;
        push_steps(512, 1'b0, 2'b00, 9'h000);
        start_sweep(2'b00, 1'b0, 9'h000);
        run_sweep(2000, ab);
        end_checks(pd, 1, 512, 1'b0);
        chk("busy_start_func", 32'(SWP_FUNC), 32'd0);
        chk("busy_start_page", 32'(SWP_PAGE), 32'd0);
        busy_step = -1;

        // Reset at step 200 aborts without a done cycle; next sweep restarts at 0.
        pd = done_cnt; rst_step = 200;
        push_steps(201, 1'b0, 2'b01, 9'h0AA);
        start_sweep(2'b01, 1'b0, 9'h0AA);
        run_sweep(2000, ab);
        chk("reset_reached", 32'(ab), 32'd1);
        chk_reset_vals();
        RESET = 1'b0; SWP_ACK = 1'b0; rst_step = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_on_reset", 32'(done_cnt), 32'(pd));
        chk("reset_run", 32'(last_run), 32'd201);
        chk("reset_sb_empty", 32'(sb.size()), 32'd0);
        pd = done_cnt;
        push_steps(512, 1'b0, 2'b01, 9'h000);
        start_sweep(2'b01, 1'b0, 9'h000);
        run_sweep(2000, ab);
        end_checks(pd, 1, 512, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
